cascade_stage_sequencer: RTL

//  Sequences one detection window through the Haar cascade. Walks the stage table, fetches each

---
 rtl/cascade_stage_sequencer_pkg.sv | 24 ++
 rtl/cascade_stage_sequencer_sat_accumulator.sv | 34 +++
 rtl/cascade_stage_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cascade_stage_sequencer_pkg.sv
// Shared types for the Haar cascade sequencer: FSM encoding, datapath width,
// saturation limits and the stage pass test.
package cascade_stage_sequencer_pkg;

   localparam int DW = 16;

   localparam logic signed [DW-1:0] SUM_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] SUM_MIN = {1'b1, {(DW-1){1'b0}}};

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_STG_RD   = 3'd1;
   localparam logic [2:0] S_STG_WAIT = 3'd2;
   localparam logic [2:0] S_FEAT_RD  = 3'd3;
   localparam logic [2:0] S_WC_WAIT  = 3'd4;
   localparam logic [2:0] S_CHECK    = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   // A stage passes when its sum reaches the threshold; equality passes.
   function automatic logic stage_pass(input logic signed [DW-1:0] sum,
                                       input logic signed [DW-1:0] thresh);
      return sum >= thresh;
   endfunction

endpackage

// File: rtl/cascade_stage_sequencer_sat_accumulator.sv
// Signed stage-sum register with saturating add; clear wins over add.
// One cycle from add_en to updated sum.
module cascade_stage_sequencer_sat_accumulator
   import cascade_stage_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 add_en,
   input  logic signed [DW-1:0] din,
   output logic signed [DW-1:0] sum
);

   logic [DW:0]          wide;
   logic signed [DW-1:0] sat;

   // One guard bit: overflow shows as the top two bits disagreeing.
   always_comb begin
      wide = {sum[DW-1], sum} + {din[DW-1], din};
      sat  = wide[DW-1:0];
      if (wide[DW] != wide[DW-1]) begin
         sat = wide[DW] ? SUM_MIN : SUM_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sat;
      end
   end

endmodule

// File: rtl/cascade_stage_sequencer.sv
// Walks one detection window through the cascade stage table and weak classifier.
// Per stage: 3 + 2*nfeat cycles plus classifier response cycles; start ignored while busy.
module cascade_stage_sequencer
   import cascade_stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES = 25,
   parameter int STAGE_AW   = 5,
   parameter int FEAT_AW    = 12,
   parameter int WC_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  face_detected,
   output logic [STAGE_AW-1:0]   reject_stage,
   output logic                  error,
   output logic                  stage_rd_en,
   output logic [STAGE_AW-1:0]   stage_addr,
   input  logic [FEAT_AW-1:0]    stage_nfeat,
   input  logic signed [DW-1:0]  stage_thresh,
   output logic                  feat_rd_en,
   output logic [FEAT_AW-1:0]    feat_addr,
   output logic                  wc_load,
   output logic                  wc_abort,
   input  logic                  wc_valid,
   input  logic signed [DW-1:0]  wc_value
);

   localparam int TW = $clog2(WC_TIMEOUT + 1);
   localparam logic [TW-1:0]       TO_LAST    = TW'(WC_TIMEOUT - 1);
   localparam logic [STAGE_AW-1:0] LAST_STAGE = STAGE_AW'(NUM_STAGES - 1);

   logic [2:0]           state;
   logic [STAGE_AW-1:0]  stage_idx;
   logic [FEAT_AW-1:0]   feat_ptr;
   logic [FEAT_AW-1:0]   feat_cnt;
   logic [FEAT_AW-1:0]   nfeat_q;
   logic signed [DW-1:0] thresh_q;
   logic signed [DW-1:0] sum;
   logic [TW-1:0]        timer;
   logic                 acc_clear;
   logic                 acc_add;

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign stage_rd_en = (state == S_STG_RD);
   assign feat_rd_en  = (state == S_FEAT_RD);
   assign wc_load     = (state == S_WC_WAIT) && (timer == '0);
   assign wc_abort    = (state == S_IDLE) || (state == S_DONE);
   assign stage_addr  = stage_idx;
   assign feat_addr   = feat_ptr;

   assign acc_clear = (state == S_IDLE) || (state == S_CHECK);
   assign acc_add   = (state == S_WC_WAIT) && wc_valid;

   cascade_stage_sequencer_sat_accumulator u_acc (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .add_en (acc_add),
      .din    (wc_value),
      .sum    (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         stage_idx     <= '0;
         feat_ptr      <= '0;
         feat_cnt      <= '0;
         nfeat_q       <= '0;
         thresh_q      <= '0;
         timer         <= '0;
         face_detected <= 1'b0;
         reject_stage  <= '0;
         error         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  stage_idx     <= '0;
                  feat_ptr      <= '0;
                  face_detected <= 1'b0;
                  reject_stage  <= '0;
                  error         <= 1'b0;
                  state         <= S_STG_RD;
               end
            end
            S_STG_RD: state <= S_STG_WAIT;
            S_STG_WAIT: begin
               nfeat_q  <= stage_nfeat;
               thresh_q <= stage_thresh;
               feat_cnt <= '0;
               state    <= (stage_nfeat == '0) ? S_CHECK : S_FEAT_RD;
            end
            S_FEAT_RD: begin
               timer <= '0;
               state <= S_WC_WAIT;
            end
            // timer == 0 marks the wc_load cycle, so a result in that cycle counts.
            S_WC_WAIT: begin
               if (wc_valid) begin
                  feat_ptr <= feat_ptr + 1'b1;
                  feat_cnt <= feat_cnt + 1'b1;
                  state    <= (feat_cnt + 1'b1 == nfeat_q) ? S_CHECK : S_FEAT_RD;
               end else if (timer == TO_LAST) begin
                  error         <= 1'b1;
                  face_detected <= 1'b0;
                  reject_stage  <= '0;
                  state         <= S_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_CHECK: begin
               if (stage_pass(sum, thresh_q)) begin
                  if (stage_idx == LAST_STAGE) begin
                     face_detected <= 1'b1;
                     state         <= S_DONE;
                  end else begin
                     stage_idx <= stage_idx + 1'b1;
                     state     <= S_STG_RD;
                  end
               end else begin
                  face_detected <= 1'b0;
                  reject_stage  <= stage_idx;
                  state         <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
